// File: rtl/ac97_cmd_arbiter.sv
//-----------------------------------------------------------------------------
// ac97_cmd_arbiter
//
// Owns the AC-link command channel (out slots 1/2). It arbitrates codec
// register read/write requests from two requesters:
//   - req0: power-up config sequencer
//   - req1: host/debug port
// It issues at most one command per frame and matches read status returned in
// in-slots 1/2. All frame timing comes from the link's ac97_strobe.
//
// Optional feature macro: AC97_CMD_WRITE_VERIFY_EN
//   When defined, every write is followed by a readback of the same address.
//   The write's response carries the readback data, and rsp_err is set on a
//   data mismatch or on a timeout.
//
// Ports:
//   ac97_bitclk / ac97_rst_b      sole clock, async active-low reset
//   ac97_strobe                   one-cycle frame strobe (frame bit 0)
//   ac97_in_slot1/2 (+_valid)     latched status address / data slots
//   ac97_out_slot1/2 (+_valid)    command address / data slots to the link
//   reqN_valid/write/addr/wdata   request from requester N (N = 0, 1)
//   reqN_ready                    one-cycle grant pulse
//   rsp_valid/id/rdata/err        one-cycle completion pulse plus held result
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module ac97_cmd_arbiter #(
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic        ac97_bitclk,
    input  logic        ac97_rst_b,
    input  logic        ac97_strobe,
    input  logic [19:0] ac97_in_slot1,
    input  logic        ac97_in_slot1_valid,
    input  logic [19:0] ac97_in_slot2,
    input  logic        ac97_in_slot2_valid,
    output logic [19:0] ac97_out_slot1,
    output logic        ac97_out_slot1_valid,
    output logic [19:0] ac97_out_slot2,
    output logic        ac97_out_slot2_valid,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [6:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [6:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ISSUE        = 2'd1,
        ST_WAIT_RD      = 2'd2,
        ST_VERIFY_ISSUE = 2'd3
    } state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic             cur_id_r;
    logic             cur_write_r;
    logic [6:0]       cur_addr_r;
    logic [CNT_W-1:0] frame_cnt_r;
`ifdef AC97_CMD_WRITE_VERIFY_EN
    logic [15:0]      cur_wdata_r;
    logic             verify_r;
`endif

    logic             any_req_s;
    logic             grant_id_s;
    logic             sel_write_s;
    logic [6:0]       sel_addr_s;
    logic [15:0]      sel_wdata_s;
    logic             match_s;
    logic             unused_bits_s;

    assign any_req_s = req0_valid | req1_valid;

    // A status frame only counts when both tags are set and the echoed
    // register address equals the address of the outstanding read.
    assign match_s = ac97_in_slot1_valid & ac97_in_slot2_valid &
                     (ac97_in_slot1[18:12] == cur_addr_r);

    // The remaining status bits carry nothing this block needs.
    assign unused_bits_s = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

    // Round-robin choice: on a tie the requester not granted last time wins.
    always_comb begin
        grant_id_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Select the fields of the granted requester.
    always_comb begin
        sel_write_s = req0_write;
        sel_addr_s  = req0_addr;
        sel_wdata_s = req0_wdata;
        if (grant_id_s) begin
            sel_write_s = req1_write;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_write_s = req0_write;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

    // Command FSM. State and slots advance only on strobe edges; the grant and
    // response pulses drop back to 0 on the following cycle.
    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            state_r              <= ST_IDLE;
            last_grant_r         <= 1'b1;
            cur_id_r             <= 1'b0;
            cur_write_r          <= 1'b0;
            cur_addr_r           <= 7'h00;
            frame_cnt_r          <= '0;
            ac97_out_slot1       <= 20'h00000;
            ac97_out_slot1_valid <= 1'b0;
            ac97_out_slot2       <= 20'h00000;
            ac97_out_slot2_valid <= 1'b0;
            req0_ready           <= 1'b0;
            req1_ready           <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_id               <= 1'b0;
            rsp_rdata            <= 16'h0000;
            rsp_err              <= 1'b0;
`ifdef AC97_CMD_WRITE_VERIFY_EN
            cur_wdata_r          <= 16'h0000;
            verify_r             <= 1'b0;
`endif
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp_valid  <= 1'b0;
            if (ac97_strobe) begin
                case (state_r)
                    ST_IDLE: begin
                        if (any_req_s) begin
                            req0_ready           <= ~grant_id_s;
                            req1_ready           <= grant_id_s;
                            last_grant_r         <= grant_id_s;
                            cur_id_r             <= grant_id_s;
                            cur_write_r          <= sel_write_s;
                            cur_addr_r           <= sel_addr_s;
                            // Bit 19 of slot 1 is the read flag.
                            ac97_out_slot1       <= {~sel_write_s, sel_addr_s, 12'h000};
                            ac97_out_slot1_valid <= 1'b1;
                            ac97_out_slot2       <= sel_write_s ? {sel_wdata_s, 4'h0} : 20'h00000;
                            ac97_out_slot2_valid <= sel_write_s;
`ifdef AC97_CMD_WRITE_VERIFY_EN
                            cur_wdata_r          <= sel_wdata_s;
                            verify_r             <= 1'b0;
`endif
                            state_r              <= ST_ISSUE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ISSUE: begin
                        ac97_out_slot2       <= 20'h00000;
                        ac97_out_slot2_valid <= 1'b0;
                        if (cur_write_r) begin
`ifdef AC97_CMD_WRITE_VERIFY_EN
                            // Follow the write with a readback of the same register.
                            ac97_out_slot1       <= {1'b1, cur_addr_r, 12'h000};
                            ac97_out_slot1_valid <= 1'b1;
                            verify_r             <= 1'b1;
                            state_r              <= ST_VERIFY_ISSUE;
`else
                            ac97_out_slot1       <= 20'h00000;
                            ac97_out_slot1_valid <= 1'b0;
                            rsp_valid            <= 1'b1;
                            rsp_id               <= cur_id_r;
                            rsp_rdata            <= 16'h0000;
                            rsp_err              <= 1'b0;
                            state_r              <= ST_IDLE;
`endif
                        end else begin
                            // Status returned during this frame is stale, so
                            // checking starts only at the next strobe.
                            ac97_out_slot1       <= 20'h00000;
                            ac97_out_slot1_valid <= 1'b0;
                            frame_cnt_r          <= '0;
                            state_r              <= ST_WAIT_RD;
                        end
                    end
`ifdef AC97_CMD_WRITE_VERIFY_EN
                    ST_VERIFY_ISSUE: begin
                        ac97_out_slot1       <= 20'h00000;
                        ac97_out_slot1_valid <= 1'b0;
                        frame_cnt_r          <= '0;
                        state_r              <= ST_WAIT_RD;
                    end
`endif
                    ST_WAIT_RD: begin
                        if (match_s) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= cur_id_r;
                            rsp_rdata <= ac97_in_slot2[19:4];
`ifdef AC97_CMD_WRITE_VERIFY_EN
                            rsp_err   <= verify_r & (ac97_in_slot2[19:4] != cur_wdata_r);
                            verify_r  <= 1'b0;
`else
                            rsp_err   <= 1'b0;
`endif
                            state_r   <= ST_IDLE;
                        end else if (frame_cnt_r == CNT_LAST) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= cur_id_r;
                            rsp_rdata <= 16'hFFFF;
                            rsp_err   <= 1'b1;
`ifdef AC97_CMD_WRITE_VERIFY_EN
                            verify_r  <= 1'b0;
`endif
                            state_r   <= ST_IDLE;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_ac97_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ac97_strobe;
    logic [19:0] in_slot1, in_slot2;
    logic        in_slot1_valid, in_slot2_valid;
    logic [19:0] out_slot1, out_slot2;
    logic        out_slot1_valid, out_slot2_valid;
    logic        req0_valid, req0_write, req0_ready;
    logic [6:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_write, req1_ready;
    logic [6:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [15:0] rsp_rdata;

    typedef struct packed {
        logic        id;
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ac97_cmd_arbiter #(.TIMEOUT_FRAMES(8)) dut (
        .ac97_bitclk          (clk),
        .ac97_rst_b           (rst_b),
        .ac97_strobe          (ac97_strobe),
        .ac97_in_slot1        (in_slot1),
        .ac97_in_slot1_valid  (in_slot1_valid),
        .ac97_in_slot2        (in_slot2),
        .ac97_in_slot2_valid  (in_slot2_valid),
        .ac97_out_slot1       (out_slot1),
        .ac97_out_slot1_valid (out_slot1_valid),
        .ac97_out_slot2       (out_slot2),
        .ac97_out_slot2_valid (out_slot2_valid),
        .req0_valid           (req0_valid),
        .req0_write           (req0_write),
        .req0_addr            (req0_addr),
        .req0_wdata           (req0_wdata),
        .req0_ready           (req0_ready),
        .req1_valid           (req1_valid),
        .req1_write           (req1_write),
        .req1_addr            (req1_addr),
        .req1_wdata           (req1_wdata),
        .req1_ready           (req1_ready),
        .rsp_valid            (rsp_valid),
        .rsp_id               (rsp_id),
        .rsp_rdata            (rsp_rdata),
        .rsp_err              (rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_b === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id=%0d rdata=0x%0h err=%0d, expected none",
                         rsp_id, rsp_rdata, rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // One frame strobe; returns just after the strobe edge for sampling.
    task automatic strobe();
        repeat (3) @(negedge clk);
        ac97_strobe = 1'b1;
        @(posedge clk);
        #1;
        ac97_strobe = 1'b0;
    endtask

    task automatic clear_status();
        in_slot1 = 20'h00000; in_slot2 = 20'h00000;
        in_slot1_valid = 1'b0; in_slot2_valid = 1'b0;
    endtask

    task automatic chk_slots_idle(input string tag);
        chk({tag, "_slot1"}, {12'd0, out_slot1}, 32'h0);
        chk({tag, "_slot1_valid"}, {31'd0, out_slot1_valid}, 32'h0);
        chk({tag, "_slot2_valid"}, {31'd0, out_slot2_valid}, 32'h0);
    endtask

    // Grant strobe: check ready pulse and command slots, then retire the request.
    task automatic issue_check(input logic id, input logic [19:0] e1, input logic [19:0] e2,
                               input logic v2);
        strobe();
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, ~id});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, id});
        chk("out_slot1", {12'd0, out_slot1}, {12'd0, e1});
        chk("out_slot1_valid", {31'd0, out_slot1_valid}, 32'h1);
        chk("out_slot2", {12'd0, out_slot2}, {12'd0, e2});
        chk("out_slot2_valid", {31'd0, out_slot2_valid}, {31'd0, v2});
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Completion of a write already granted (readback frames when verifying).
    task automatic write_complete(input logic id, input logic [6:0] addr,
                                  input logic [15:0] rb, input logic exp_err);
`ifdef AC97_CMD_WRITE_VERIFY_EN
        strobe();
        chk("verify_slot1", {12'd0, out_slot1}, {12'd0, 1'b1, addr, 12'h000});
        chk("verify_slot1_valid", {31'd0, out_slot1_valid}, 32'h1);
        chk("verify_slot2_valid", {31'd0, out_slot2_valid}, 32'h0);
        strobe();
        chk_slots_idle("verify_done");
        in_slot1 = {1'b0, addr, 12'h000}; in_slot1_valid = 1'b1;
        in_slot2 = {rb, 4'h0};            in_slot2_valid = 1'b1;
        exp_q.push_back('{id: id, rdata: rb, err: exp_err});
        strobe();
        clear_status();
`else
        exp_q.push_back('{id: id, rdata: 16'h0000, err: 1'b0});
        strobe();
        chk_slots_idle("write_done");
        if (rb != 16'h0000 && exp_err && addr == 7'h7F) $display("note: unused args");
`endif
    endtask

    logic        c_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [19:0] c_s1   [4] = '{20'h10000, 20'h11000, 20'h12000, 20'h13000};
    logic [19:0] c_s2   [4] = '{20'h11110, 20'h22220, 20'h33330, 20'h44440};
    logic [6:0]  c_addr [4] = '{7'h10, 7'h11, 7'h12, 7'h13};
    logic [15:0] c_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        rst_b = 1'b0; ac97_strobe = 1'b0;
        clear_status();
        // Both requesters already pending while reset is held.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 7'h02; req0_wdata = 16'h0808;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 7'h26; req1_wdata = 16'h0000;
        repeat (4) @(posedge clk);
        #1;
        chk_slots_idle("reset");
        chk("reset_slot2", {12'd0, out_slot2}, 32'h0);
        chk("reset_ready", {30'd0, req0_ready, req1_ready}, 32'h0);
        chk("reset_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'h0);
        @(negedge clk);
        rst_b = 1'b1;

        // Write 0x02 = 0x0808 from req0 wins the first tie.
        issue_check(1'b0, 20'h02000, 20'h08080, 1'b1);
        write_complete(1'b0, 7'h02, 16'h0808, 1'b0);

        // Read 0x26 from req1; status returned in the first checked frame.
        issue_check(1'b1, 20'hA6000, 20'h00000, 1'b0);
        strobe();
        chk_slots_idle("read_s1");
        in_slot1 = 20'h26000; in_slot1_valid = 1'b1;
        in_slot2 = 20'h000F0; in_slot2_valid = 1'b1;
        exp_q.push_back('{id: 1'b1, rdata: 16'h000F, err: 1'b0});
        strobe();
        clear_status();

        // Read 0x7C times out; status in the S1 frame and near-misses are ignored.
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 7'h7C;
        issue_check(1'b1, 20'hFC000, 20'h00000, 1'b0);
        in_slot1 = 20'h7C000; in_slot1_valid = 1'b1;
        in_slot2 = 20'h12340; in_slot2_valid = 1'b1;
        strobe();
        clear_status();
        exp_q.push_back('{id: 1'b1, rdata: 16'hFFFF, err: 1'b1});
        for (int k = 2; k <= 8; k++) begin
            if (k == 4) begin
                in_slot1 = 20'h7B000; in_slot1_valid = 1'b1;
                in_slot2 = 20'h55550; in_slot2_valid = 1'b1;
            end else if (k == 5) begin
                in_slot1 = 20'h7C000; in_slot1_valid = 1'b1;
                in_slot2 = 20'h55550; in_slot2_valid = 1'b0;
            end else begin
                clear_status();
            end
            strobe();
        end
        clear_status();
        @(negedge clk); #1;
        chk("timeout_not_before_s9", exp_q.size(), 32'd1);
        strobe();
        @(negedge clk); #1;
        chk("timeout_at_s9", exp_q.size(), 32'd0);

        // Repeated contention alternates 0,1,0,1.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = c_addr[0]; req0_wdata = c_data[0];
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = c_addr[1]; req1_wdata = c_data[1];
        for (int i = 0; i < 4; i++) begin
            issue_check(c_id[i], c_s1[i], c_s2[i], 1'b1);
            if (i < 2) begin
                if (c_id[i]) begin
                    req1_valid = 1'b1; req1_addr = c_addr[i+2]; req1_wdata = c_data[i+2];
                end else begin
                    req0_valid = 1'b1; req0_addr = c_addr[i+2]; req0_wdata = c_data[i+2];
                end
            end
            write_complete(c_id[i], c_addr[i], c_data[i], 1'b0);
        end

        // Reset while waiting for read status drops the transaction.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 7'h05;
        issue_check(1'b0, 20'h85000, 20'h00000, 1'b0);
        strobe();
        strobe();
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk_slots_idle("midreset");
        chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        in_slot1 = 20'h05000; in_slot1_valid = 1'b1;
        in_slot2 = 20'hABCD0; in_slot2_valid = 1'b1;
        strobe();
        strobe();
        clear_status();
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 7'h20; req1_wdata = 16'h1234;
        issue_check(1'b1, 20'h20000, 20'h12340, 1'b1);
        write_complete(1'b1, 7'h20, 16'h1234, 1'b0);

`ifdef AC97_CMD_WRITE_VERIFY_EN
        // Readback mismatch flags an error; a matching readback does not.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 7'h18; req0_wdata = 16'h0808;
        issue_check(1'b0, 20'h18000, 20'h08080, 1'b1);
        write_complete(1'b0, 7'h18, 16'h8808, 1'b1);
        req0_valid = 1'b1;
        issue_check(1'b0, 20'h18000, 20'h08080, 1'b1);
        write_complete(1'b0, 7'h18, 16'h0808, 1'b0);
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
